fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the monocycle processor. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, captures the returned word and presents it with its PC to decode under a valid/ready handshake. It is the consumer of the PC+4 path and the entry point for branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- XLEN, 32, address/data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  XLEN  word address of request (= pc)
- imem_req_ready  in  1  memory accepts request when high with valid
- imem_rsp_valid  in  1  read data valid (one cycle)
- imem_rsp_data  in  XLEN  instruction word
- inst_valid  out  1  instruction available to decode
- inst_data  out  XLEN  instruction word
- inst_pc  out  XLEN  PC of inst_data
- inst_ready  in  1  decode consumes instruction when high with inst_valid
- redirect_valid  in  1  branch/jump taken, load redirect_pc
- redirect_pc  in  XLEN  new fetch address
- fetch_fault  out  1  misaligned redirect (only with FETCH_ALIGN_CHECK_EN; else tied 0)

## Operation
- States: IDLE, REQ, WAIT, HOLD (plus FAULT with macro).
- IDLE: entered only from reset; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready -> WAIT. Address stable until accepted unless redirected.
- WAIT: on imem_rsp_valid: capture inst_data=rsp_data, inst_pc=pc -> HOLD. Exactly one outstanding request.
- HOLD: inst_valid=1; outputs stable. On inst_valid&inst_ready: pc <= pc+4 -> REQ.
- PC+4 is modulo 2^XLEN: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect (highest priority, any state except IDLE):
  - REQ: pc <= redirect_pc, stay REQ; new address presented next cycle (request not accepted that cycle is dropped; if accepted same cycle, treat as WAIT case below).
  - WAIT: pc <= redirect_pc, set kill flag; response for old request is discarded when it arrives, then -> REQ.
  - HOLD: held instruction flushed (inst_valid low next cycle), pc <= redirect_pc -> REQ, even if inst_ready high same cycle.
- imem_rsp_valid outside WAIT is ignored.

## Timing
- Reset (async assert): pc=RESET_PC, state IDLE, kill=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0. Release: IDLE one cycle, REQ on the next.
- Request accepted cycle N; response earliest N+1; inst_valid rises the edge after the response cycle.
- Zero-wait memory: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect takes effect on the next edge; imem_req_addr shows redirect_pc in the following cycle.
- All outputs registered; no combinational path input->output except none (imem_req_valid/addr derived from state/pc only).
- Reset mid-WAIT: the late response after release is ignored (state IDLE/REQ).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT state, fetch_fault=1, imem_req_valid=0, inst_valid=0; sticky until reset or an aligned redirect (-> REQ, fetch_fault clears next edge). Pending response in flight is discarded.
- Not defined: redirect_pc[1:0] forced to 2'b00, fetch_fault tied 0, no FAULT state.

## Structure
- Shared processor package: fetch state enum, XLEN constant, PC increment constant (4), RESET_PC default.
- PC+4 computed by instantiating the existing Adder module (pc_in=pc, pc_out=pc_plus4); no other sub-module.

## Test plan
- Reset, RESET_PC=0, ready always 1, rsp one cycle after accept with 32'h00000013 -> inst_pc sequence 0,4,8; inst_valid every 3rd cycle.
- inst_ready held low 5 cycles in HOLD -> inst_data/inst_pc stable, no new imem request; then ready -> next req addr = pc+4.
- Redirect to 32'h00001000 during WAIT -> old response dropped, next req addr 32'h00001000, inst_pc 32'h00001000.
- Redirect in HOLD with inst_ready=1 same cycle -> instruction flushed, next req addr = redirect_pc.
- RESET_PC=32'hFFFFFFFC -> second fetch address 32'h00000000.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h00000102 -> fetch_fault=1, no requests; redirect 32'h00000100 -> fault clears, req addr 32'h00000100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, PC step, reset vector and FSM states.
// FETCH_ALIGN_CHECK_EN adds the FAULT state used for misaligned redirects.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_unit_adder.sv
// PC incrementer: pc_out = pc_in + INC, modulo 2^WIDTH.
// Purely combinational; no flow control.
module adder
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH = XLEN,
    parameter logic [WIDTH-1:0] INC   = PC_INC
) (
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out
);

    assign pc_out = pc_in + INC;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, captured word held for decode.
// Latency: accept at N, response >= N+1, inst_valid the edge after; 3 cycles/instr at zero wait.
// Backpressure: HOLD keeps inst_* stable and issues nothing until inst_ready. Macro: FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redir_pc;

    adder #(.WIDTH(XLEN), .INC(PC_INC)) u_pc_adder (
        .pc_in  (pc_q),
        .pc_out (pc_plus4)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic redir_bad;
    assign redir_pc  = redirect_pc;
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc  = redirect_pc & ALIGN_MASK;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        kill_d      = kill_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    // old address slipped out this cycle: its response must be dropped
                    if (imem_req_ready) begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_rsp_valid) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = pc_q;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_plus4;
                    state_d = ST_REQ;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_FAULT: begin
                if (redirect_valid && !redir_bad) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned target overrides everything; any in-flight response is abandoned
        if (state_q != ST_IDLE && redir_bad) begin
            pc_d    = pc_q;
            state_d = ST_FAULT;
            kill_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            kill_q      <= kill_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == ST_HOLD);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault    = (state_q == ST_FAULT);
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus, scoreboard of expected fetch PCs.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // environment knobs
    int ready_pct   = 100;
    int mem_dly_min = 0;
    int mem_dly_max = 0;
    int spur_pct    = 0;

    // scoreboard state
    logic [31:0] exp_q[$];
    int          cons_cnt   = 0;
    int          cyc        = 0;
    int          last_cons  = -1;
    bit          chk_period = 1'b0;
    bit          exp_fault  = 1'b0;
    bit          prev_hold  = 1'b0;
    logic [31:0] prev_data, prev_pc;

    // memory model state
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or nothing expected)", name);
    endtask

    // instruction memory: one response per accepted request after a random delay
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                check_b("single_outstanding", mem_pend, 1'b0);
                mem_pend = 1'b1;
                mem_cnt  = $urandom_range(mem_dly_max, mem_dly_min);
                mem_addr = imem_req_addr;
            end
            @(posedge clk);
            #1;
            imem_req_ready = ($urandom_range(99, 0) < ready_pct);
            if (mem_pend && mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 1'b0;
            end else begin
                if (mem_pend) mem_cnt--;
                if (!mem_pend && $urandom_range(99, 0) < spur_pct) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = 32'hDEAD_BEEF;
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // monitor + reference model: next expected fetch PC is pc+4 after a consume, target after a redirect
    initial begin
        logic [31:0] nxt;
        forever begin
            @(negedge clk);
            cyc++;
            if (!chk_period) last_cons = -1;
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
                exp_fault = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check_b("hold_valid", inst_valid, 1'b1);
                    check("hold_data", inst_data, prev_data);
                    check("hold_pc", inst_pc, prev_pc);
                end
                if (inst_valid) check_b("no_req_in_hold", imem_req_valid, 1'b0);
                check_b("fetch_fault", fetch_fault, exp_fault);
                if (exp_fault) begin
                    check_b("fault_no_req", imem_req_valid, 1'b0);
                    check_b("fault_no_inst", inst_valid, 1'b0);
                end
                if (imem_req_valid && imem_req_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) fail_now("req_unexpected");
                    else check("req_addr", imem_req_addr, exp_q[0]);
                end
                if (inst_valid && inst_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("inst_unexpected");
                    end else begin
                        check("inst_pc", inst_pc, exp_q[0]);
                        check("inst_data", inst_data, mem_word(exp_q[0]));
                        nxt = exp_q.pop_front() + 32'd4;
                        exp_q.push_back(nxt);
                        cons_cnt++;
                        if (chk_period && last_cons >= 0) check("period", 32'(cyc - last_cons), 32'd3);
                        last_cons = cyc;
                    end
                end
                prev_hold = inst_valid && !inst_ready && !redirect_valid;
                prev_data = inst_data;
                prev_pc   = inst_pc;
                if (redirect_valid) begin
                    exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        exp_fault = 1'b1;
                    end else begin
                        exp_fault = 1'b0;
                        exp_q.push_back(redirect_pc);
                    end
`else
                    exp_q.push_back({redirect_pc[31:2], 2'b00});
`endif
                end
            end
        end
    end

    task automatic wait_cons(input int n_more, input int budget);
        int tgt;
        int n;
        tgt = cons_cnt + n_more;
        n   = 0;
        while (cons_cnt < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cons_cnt < tgt) fail_now("wait_consume_timeout");
    endtask

    task automatic wait_hold();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!inst_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inst_valid) fail_now("wait_hold_timeout");
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!(imem_req_valid && imem_req_ready) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(imem_req_valid && imem_req_ready)) fail_now("wait_accept_timeout");
    endtask

    // redirect in HOLD with inst_ready high; held word must be flushed
    task automatic redirect_in_hold(input logic [31:0] tgt, input logic [31:0] exp_addr);
        inst_ready = 1'b1;
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_b("flush_inst_valid", inst_valid, 1'b0);
        check_b("redir_req_valid", imem_req_valid, 1'b1);
        check("redir_req_addr", imem_req_addr, exp_addr);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        check_b("rst_req_valid", imem_req_valid, 1'b0);
        check_b("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check_b("rst_fault", fetch_fault, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        check_b("idle_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        check_b("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RST_PC);

        // zero-wait streaming: one instruction every 3 cycles
        chk_period = 1'b1;
        wait_cons(4, 40);
        chk_period = 1'b0;

        // decode stall in HOLD
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        wait_hold();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_b("stall_still_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        wait_cons(2, 40);

        // redirect during WAIT kills the outstanding response
        mem_dly_min = 2;
        mem_dly_max = 2;
        wait_accept();
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("wait_redir_no_req", 32'(imem_req_valid), 32'd0);
        wait_cons(1, 40);
        mem_dly_min = 0;
        mem_dly_max = 0;

        redirect_in_hold(32'h0000_2000, 32'h0000_2000);
        wait_cons(1, 40);

        // PC wrap at the top of the address space
        redirect_in_hold(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        wait_cons(2, 40);

`ifdef FETCH_ALIGN_CHECK_EN
        inst_ready = 1'b1;
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_b("fault_set", fetch_fault, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_b("fault_sticky", fetch_fault, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_b("fault_clear", fetch_fault, 1'b0);
        check("fault_exit_addr", imem_req_addr, 32'h0000_0100);
        wait_cons(1, 40);
`else
        redirect_in_hold(32'h0000_3002, 32'h0000_3000);
        wait_cons(1, 40);
`endif

        // reset while WAIT: the late response must be ignored
        mem_dly_min = 2;
        mem_dly_max = 2;
        wait_accept();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mem_dly_min = 0;
        mem_dly_max = 0;
        check_b("post_rst_idle", imem_req_valid, 1'b0);
        wait_cons(2, 40);

        // randomized traffic
        ready_pct   = 70;
        mem_dly_max = 3;
        spur_pct    = 10;
        c0          = cons_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            inst_ready     = ($urandom_range(99, 0) < 70);
            redirect_valid = ($urandom_range(99, 0) < 4);
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc    = $urandom & 32'h0000_FFFC;
`else
            redirect_pc    = $urandom & 32'h0000_FFFF;
`endif
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) @(negedge clk);
        check_b("random_progress", (cons_cnt - c0) > 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
